// File: rtl/apu_pkg.sv
// Shared types and protocol constants for the square-channel serial loader.
package apu_pkg;

  typedef logic [1:0] reg_idx_t;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

  localparam int NIB_SEL_BIT  = 4;
  localparam int IDX_LSB      = 5;
  localparam int CMD_MARK_BIT = 7;

  localparam int DEFAULT_BAUD   = 9600;
  localparam int DEFAULT_CLK_HZ = 12000000;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: rx synchronizer, bit-timing FSM, byte_valid / frame_err pulses.
// UART_MAJORITY_EN selects 2-of-3 voting around each mid-bit sample.
module uart_rx_core
  import apu_pkg::*;
#(
  parameter int DIVISOR = 1250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(DIVISOR);
  localparam logic [CW-1:0] HALF_LD = CW'(DIVISOR / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(DIVISOR - 1);

  logic          rx_m, rx_s;
  rx_state_e     state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          tick, bit_val;
  logic          done, ferr, shift_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

`ifdef UART_MAJORITY_EN
  // Samples at cnt==1 and cnt==0 are held; the vote and the decision land one cycle later.
  logic s1, s0, tick_d;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1     <= 1'b1;
      s0     <= 1'b1;
      tick_d <= 1'b0;
    end else begin
      tick_d <= (state != IDLE) && (cnt == '0);
      if (cnt == CW'(1)) s1 <= rx_s;
      if (cnt == '0)     s0 <= rx_s;
    end
  end
  assign tick    = tick_d;
  assign bit_val = maj3(s1, s0, rx_s);
`else
  assign tick    = (state != IDLE) && (cnt == '0);
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!rx_s) state_nxt = START;
      START: if (tick)  state_nxt = bit_val ? IDLE : DATA;
      DATA:  if (tick && idx == 3'd7) state_nxt = STOP;
      STOP:  if (tick)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done     = (state == STOP) && tick && bit_val;
    ferr     = (state == STOP) && tick && !bit_val;
    shift_en = (state == DATA) && tick;
  end

  // Counter free-runs with reload on every expiry outside IDLE, so bit spacing stays exact.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= HALF_LD;
      idx        <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      if (state == IDLE)   cnt <= HALF_LD;
      else if (cnt == '0)  cnt <= FULL_LD;
      else                 cnt <= cnt - 1'b1;
      if (state == START && tick) idx <= '0;
      if (shift_en) begin
        shift[idx] <= bit_val;
        idx        <= idx + 1'b1;
      end
      byte_valid <= done;
      frame_err  <= ferr;
      if (done) byte_data <= shift;
    end
  end

endmodule

// File: rtl/uart_apu_loader.sv
// Serial front end of the audio core: turns nibble-pair bytes into square-channel register writes.
// Optional macro UART_MAJORITY_EN enables majority-vote bit sampling in the receiver.
module uart_apu_loader
  import apu_pkg::*;
#(
  parameter int CLK_HZ = DEFAULT_CLK_HZ,
  parameter int BAUD   = DEFAULT_BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       wr_en,
  output logic [1:0] wr_addr,
  output logic [7:0] wr_data
);

  // Clocks per bit; must stay >= 16 for the half-bit start check to make sense.
  localparam int DIVISOR = CLK_HZ / BAUD;

  uart_rx_core #(.DIVISOR(DIVISOR)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  logic       hold_valid;
  reg_idx_t   hold_idx, byte_idx;
  logic [3:0] hold_nib;

  assign byte_idx = byte_data[IDX_LSB +: 2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_idx   <= '0;
      hold_nib   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      wr_en <= 1'b0;
      if (frame_err) begin
        hold_valid <= 1'b0;
      end else if (byte_valid && !byte_data[CMD_MARK_BIT]) begin
        if (!byte_data[NIB_SEL_BIT]) begin
          hold_idx   <= byte_idx;
          hold_nib   <= byte_data[3:0];
          hold_valid <= 1'b1;
        end else begin
          // A high byte always consumes the held nibble, matching or not.
          hold_valid <= 1'b0;
          if (hold_valid && hold_idx == byte_idx) begin
            wr_en   <= 1'b1;
            wr_addr <= hold_idx;
            wr_data <= {byte_data[3:0], hold_nib};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_apu_loader.sv
// Scoreboard bench for uart_apu_loader; runs at 32 clocks per bit to keep frames short.
`timescale 1ns/1ps
module tb_uart_apu_loader;

  localparam int DIV = 32;

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       byte_valid, frame_err, wr_en;
  logic [7:0] byte_data, wr_data;
  logic [1:0] wr_addr;

  logic [7:0] exp_b[$];
  wr_t        exp_w[$];
  bit         exp_fe[$];
  bit         rst_chk = 1'b0;
  bit         final_chk = 1'b0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  uart_apu_loader #(.CLK_HZ(9600 * DIV), .BAUD(9600)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Monitor: pops expectations as the DUT presents pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (rst_chk)
        chk("reset_outputs", 32'({byte_valid, byte_data, frame_err, wr_en, wr_addr, wr_data}), 32'd0);
    end else begin
      if (byte_valid) begin
        if (exp_b.size() == 0) chk("unexpected_byte", 32'(byte_data), 32'hFFFF);
        else chk("byte_data", 32'(byte_data), 32'(exp_b.pop_front()));
      end
      if (frame_err) begin
        if (exp_fe.size() == 0) chk("unexpected_frame_err", 32'd1, 32'd0);
        else chk("frame_err", 32'(exp_fe.pop_front()), 32'd1);
      end
      if (wr_en) begin
        if (exp_w.size() == 0) chk("unexpected_wr", 32'({wr_addr, wr_data}), 32'hFFFF);
        else begin
          wr_t w;
          w = exp_w.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(w.a));
          chk("wr_data", 32'(wr_data), 32'(w.d));
        end
      end
      if (wr_en && byte_valid) chk("wr_byte_overlap", 32'd1, 32'd0);
    end
    if (final_chk) begin
      chk("leftover_bytes", 32'(exp_b.size()), 32'd0);
      chk("leftover_writes", 32'(exp_w.size()), 32'd0);
      chk("leftover_frame_errs", 32'(exp_fe.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  task automatic send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic idle(input int bits);
    rx = 1'b1;
    repeat (bits * DIV) @(negedge clk);
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) begin
      exp_b.push_back(s[i]);
      send(s[i], 1'b1);
    end
  endtask

  task automatic exp_wr(input logic [1:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_w.push_back(w);
  endtask

  initial begin
    logic [7:0] seq[$];
    // Power-on reset, outputs checked while held
    @(posedge clk); #1 rst_chk = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1; rst_chk = 1'b0;
    idle(2);

    // Basic pair: 0x27, 0x3A -> reg1 = 0xA7
    exp_wr(2'd1, 8'hA7);
    seq = '{8'h27, 8'h3A}; send_seq(seq); idle(2);

    // Three back-to-back writes
    exp_wr(2'd0, 8'h82); exp_wr(2'd2, 8'h7C); exp_wr(2'd3, 8'h09);
    seq = '{8'h02, 8'h18, 8'h4C, 8'h57, 8'h69, 8'h70}; send_seq(seq); idle(2);

    // Index mismatch clears the held nibble; trailing high byte writes nothing
    seq = '{8'h27, 8'h19, 8'h3A}; send_seq(seq); idle(2);

    // Low stop bit: frame_err only, then decoding recovers
    exp_fe.push_back(1'b1);
    send(8'h55, 1'b0); idle(2);
    exp_wr(2'd0, 8'h9F);
    seq = '{8'h0F, 8'h19}; send_seq(seq); idle(2);

    // Start-bit glitch shorter than half a bit
    rx = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    idle(3);

    // Bytes with bit7 set leave the held nibble alone
    exp_wr(2'd1, 8'hA7);
    seq = '{8'h27, 8'h80, 8'h3A}; send_seq(seq); idle(2);

    // Reset in the middle of 0x3A's data bits after 0x27 was received
    seq = '{8'h27}; send_seq(seq);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = (i == 1);
      repeat (DIV) @(negedge clk);
    end
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_chk = 1'b1; rx = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1; rst_chk = 1'b0;
    idle(12);
    seq = '{8'h3A}; send_seq(seq); idle(2);
    exp_wr(2'd1, 8'hA7);
    seq = '{8'h27, 8'h3A}; send_seq(seq); idle(3);

    final_chk = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
